fas_frame_tx: RTL and testbench



---
 rtl/fas_pkg.sv | 14 +
 rtl/fas_frame_buf.sv | 59 +++++
 rtl/fas_frame_tx.sv | 175 +++++++++++++++++
 tb/tb_fas_frame_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fas_pkg.sv
// Shared constants and transmit FSM state type for the FAS front end.
package fas_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } tx_state_t;

endpackage

// File: rtl/fas_frame_buf.sv
// Ping-pong frame storage: two FRAME_LEN-deep sample buffers plus their full flags.
// A write at the last index marks that buffer full; the reader clears it when done.
module fas_frame_buf
    import fas_pkg::*;
#(
    parameter int  DW  = DATA_W,
    parameter int  LEN = FRAME_LEN,
    localparam int IW  = $clog2(LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [IW-1:0] wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic          clr_en,
    input  logic          clr_sel,
    input  logic          rd_sel,
    input  logic [IW-1:0] rd_idx,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    full
);

    logic [DW-1:0] mem_q [2][LEN];
    logic [1:0]    full_q;
    logic [1:0]    full_d;

    // Next full flags: completing a frame sets its flag, the reader finishing clears it.
    // Writer and reader never touch the same buffer in one cycle.
    always_comb begin
        full_d = full_q;
        if (wr_en && (wr_idx == IW'(LEN - 1))) begin
            full_d[wr_sel] = 1'b1;
        end
        if (clr_en) begin
            full_d[clr_sel] = 1'b0;
        end
    end

    // Full flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
        end else begin
            full_q <= full_d;
        end
    end

    // Sample storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_sel][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_sel][rd_idx];
    assign full    = full_q;

endmodule

// File: rtl/fas_frame_tx.sv
// Frame transmitter for the FAS analyser: buffers upstream samples into
// ping-pong frames, bursts each full frame, then waits for the analyser's done.
module fas_frame_tx #(
    parameter int DATA_W    = fas_pkg::DATA_W,
    parameter int FRAME_LEN = fas_pkg::FRAME_LEN,
    parameter int TIMEOUT   = 64,
    parameter int GAP_CYC   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     wr_ready,
    output logic                     data_valid,
    output logic signed [DATA_W-1:0] data,
    input  logic                     done,
    output logic                     busy,
    output logic [7:0]               frame_cnt,
    output logic                     err
);
    import fas_pkg::*;

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    tx_state_t          state_q, state_d;
    logic               wr_buf_q, wr_buf_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic               rd_buf_q, rd_buf_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               data_valid_q, data_valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic [1:0]         full;
    logic [DATA_W-1:0]  rd_data;
    logic               wr_accept;
    logic               clr_full;

    fas_frame_buf #(
        .DW  (DATA_W),
        .LEN (FRAME_LEN)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_sel  (wr_buf_q),
        .wr_idx  (wr_idx_q),
        .wr_data (wr_data),
        .clr_en  (clr_full),
        .clr_sel (rd_buf_q),
        .rd_sel  (rd_buf_q),
        .rd_idx  (rd_idx_q),
        .rd_data (rd_data),
        .full    (full)
    );

    assign wr_ready  = ~full[wr_buf_q];
    assign wr_accept = wr_en & wr_ready;

    // Write pointer: advance per accepted sample, flip buffers at end of frame.
    always_comb begin
        wr_idx_d = wr_idx_q;
        wr_buf_d = wr_buf_q;
        if (wr_accept) begin
            if (wr_idx_q == IDX_W'(FRAME_LEN - 1)) begin
                wr_idx_d = '0;
                wr_buf_d = ~wr_buf_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // Transmit FSM: burst a full frame, wait for done (or time out), pause, repeat.
    always_comb begin
        state_d      = state_q;
        rd_idx_d     = rd_idx_q;
        rd_buf_d     = rd_buf_q;
        tmo_d        = tmo_q;
        gap_d        = gap_q;
        frame_cnt_d  = frame_cnt_q;
        data_valid_d = 1'b0;
        data_d       = data_q;
        err_d        = 1'b0;
        clr_full     = 1'b0;
        case (state_q)
            IDLE: begin
                if (full[rd_buf_q]) begin
                    rd_idx_d = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                data_valid_d = 1'b1;
                data_d       = rd_data;
                if (rd_idx_q == IDX_W'(FRAME_LEN - 1)) begin
                    // Last sample goes out on this edge: hand the buffer back.
                    clr_full = 1'b1;
                    rd_buf_d = ~rd_buf_q;
                    rd_idx_d = '0;
                    tmo_d    = '0;
                    state_d  = WAIT_DONE;
                end else begin
                    rd_idx_d = rd_idx_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    gap_d       = '0;
                    state_d     = GAP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset discards any queued or partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_buf_q     <= 1'b0;
            wr_idx_q     <= '0;
            rd_buf_q     <= 1'b0;
            rd_idx_q     <= '0;
            tmo_q        <= '0;
            gap_q        <= '0;
            frame_cnt_q  <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_buf_q     <= wr_buf_d;
            wr_idx_q     <= wr_idx_d;
            rd_buf_q     <= rd_buf_d;
            rd_idx_q     <= rd_idx_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            frame_cnt_q  <= frame_cnt_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_valid = data_valid_q;
    assign data       = data_q;
    assign busy       = busy_q;
    assign frame_cnt  = frame_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fas_frame_tx.sv
// Scoreboard bench for fas_frame_tx: stimulus pushes expected samples,
// a negedge monitor pops and compares every data_valid beat.
module tb_fas_frame_tx;

    localparam int FRAME_LEN = 16;
    localparam int TIMEOUT   = 64;
    localparam int GAP_CYC   = 1;
    localparam int MIN_LO    = GAP_CYC + 2;

    logic               clk;
    logic               rst;
    logic               wr_en;
    logic signed [15:0] wr_data;
    logic               wr_ready;
    logic               data_valid;
    logic signed [15:0] data;
    logic               done;
    logic               busy;
    logic [7:0]         frame_cnt;
    logic               err;

    fas_frame_tx #(
        .DATA_W    (16),
        .FRAME_LEN (FRAME_LEN),
        .TIMEOUT   (TIMEOUT),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .data_valid (data_valid),
        .data       (data),
        .done       (done),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_fc   = 8'd0;
    int          exp_err  = 0;
    int          err_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: expected event did not occur", nm);
    endtask

    // Monitor: scoreboard pops, burst length, minimum idle between bursts, err pulses.
    int   run_hi = 0;
    int   run_lo = 0;
    logic prev_dv = 1'b0;
    logic prev_err = 1'b0;
    logic skip_gap = 1'b1;
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            run_hi   = 0;
            run_lo   = 0;
            prev_dv  = 1'b0;
            prev_err = 1'b0;
            skip_gap = 1'b1;
        end else begin
            if (data_valid) begin
                if (!prev_dv && !skip_gap) chk("dv_idle_between_bursts", (run_lo >= MIN_LO), 1);
                chk("busy_during_send", busy, 1);
                if (exp_q.size() == 0) fail_now("sb_unexpected_sample");
                else begin
                    e = exp_q.pop_front();
                    chk("sb_data", {16'd0, data}, {16'd0, e});
                end
                run_hi++;
                run_lo = 0;
            end else begin
                if (prev_dv) begin
                    chk("burst_len", run_hi, FRAME_LEN);
                    skip_gap = 1'b0;
                end
                run_hi = 0;
                run_lo++;
            end
            if (err && prev_err) fail_now("err_single_cycle");
            if (err && !prev_err) err_seen++;
            prev_dv  = data_valid;
            prev_err = err;
        end
    end

    task automatic wr(input logic [15:0] d, input logic exp_rdy);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        chk("wr_ready", wr_ready, exp_rdy);
        if (exp_rdy) exp_q.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_burst_end();
        int n = 0;
        @(negedge clk);
        while (data_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("burst_start_timeout");
        n = 0;
        while (data_valid === 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) fail_now("burst_end_timeout");
        @(posedge clk); #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    task automatic measure_rise(output int k);
        k = 0;
        do begin @(negedge clk); k++; end while (data_valid !== 1'b1 && k < 100);
    endtask

    task automatic chk_fc(input string nm);
        @(negedge clk);
        chk(nm, frame_cnt, exp_fc);
        @(posedge clk); #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; done = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_data", {16'd0, data}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_ready", wr_ready, 1);
        @(posedge clk); #1;

        // Basic frame 0..15 with latency check and done a few cycles after the burst.
        for (int j = 0; j < 16; j++) wr(16'(j), 1'b1);
        @(negedge clk); chk("lat_edge1", data_valid, 0);
        @(negedge clk); chk("lat_edge2", data_valid, 0);
        @(negedge clk); chk("lat_first_beat", data_valid, 1);
        @(posedge clk); #1;
        wait_burst_end();
        @(posedge clk); #1;
        pulse_done(); exp_fc++;
        chk_fc("fc_after_first");

        // Leader frame parks the FSM in WAIT_DONE while 48 samples are offered.
        for (int j = 0; j < 16; j++) wr(16'(200 + j), 1'b1);
        wait_burst_end();
        for (int i = 0; i < 48; i++) wr(16'(1000 + i), (i < 32));
        pulse_done(); exp_fc++;
        measure_rise(k);
        chk("gap_to_frame_a", k, GAP_CYC + 3);
        wait_burst_end();
        chk_fc("fc_after_leader");
        pulse_done(); exp_fc++;
        measure_rise(k);
        chk("gap_to_frame_b", k, GAP_CYC + 3);
        wait_burst_end();
        pulse_done(); exp_fc++;
        chk_fc("fc_after_frame_b");

        // Timeout: no done for frame A; err fires, then queued frame B goes out.
        for (int j = 0; j < 32; j++) wr(16'(300 + j), 1'b1);
        wait_burst_end();
        k = 0;
        do begin @(negedge clk); k++; end while (err !== 1'b1 && k < 200);
        chk("err_latency", k, TIMEOUT - 1);
        exp_err++;
        @(negedge clk); chk("err_pulse_end", err, 0);
        @(posedge clk); #1;
        wait_burst_end();
        chk_fc("fc_after_timeout");
        chk("err_count_timeout", err_seen, exp_err);
        pulse_done(); exp_fc++;
        chk_fc("fc_after_frame_b_tmo");

        // done in IDLE and during SEND must be ignored.
        repeat (4) @(posedge clk); #1;
        pulse_done();
        chk_fc("fc_done_in_idle");
        for (int j = 0; j < 16; j++) wr(((j % 2) == 0) ? 16'(-(j + 1)) : 16'(j + 1), 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (data_valid !== 1'b1 && n < 100);
        if (n >= 100) fail_now("send_start_timeout");
        @(posedge clk); #1;
        pulse_done();
        wait_burst_end();
        chk_fc("fc_done_in_send");
        pulse_done(); exp_fc++;
        chk_fc("fc_after_ignore_test");

        // Reset in the 8th cycle of a burst, then a -32768 frame.
        for (int j = 0; j < 16; j++) wr(16'(500 + j), 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (data_valid !== 1'b1 && n < 100);
        if (n >= 100) fail_now("reset_burst_start_timeout");
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_fc = 8'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_data_valid", data_valid, 0);
        chk("midrst_wr_ready", wr_ready, 1);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        for (int j = 0; j < 16; j++) wr(16'h8000, 1'b1);
        wait_burst_end();
        pulse_done(); exp_fc++;
        chk_fc("fc_after_reset_frame");

        // 255 more acknowledged frames: counter wraps back to 0.
        for (int f = 0; f < 255; f++) begin
            for (int j = 0; j < 16; j++) wr(16'(f * 37 + j * 5), 1'b1);
            wait_burst_end();
            pulse_done(); exp_fc++;
            chk_fc("fc_running");
        end
        chk("fc_wrapped", frame_cnt, 0);

        repeat (4) @(posedge clk);
        chk("sb_drained", exp_q.size(), 0);
        chk("err_count_final", err_seen, exp_err);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
